i2s_tx_ctrl: RTL
================

Name: i2s_tx_ctrl

Overview:
Sequencing controller for the I2S transmit path. It accepts stereo samples through a valid/ready handshake into a small FIFO and derives BCLK and LRCLK from clk with a programmable divider. It schedules one FIFO pop per stereo frame and serialises the samples in Philips I2S format. It sits between the audio processing pipeline (upstream) and the codec pins (downstream).

Parameters:
DATA_W, 24, sample width per channel (must be <= SLOT_W)
SLOT_W, 32, BCLK periods per channel slot; frame = 2*SLOT_W BCLK periods
BCLK_DIV, 4, clk cycles per BCLK period (even, >= 2)
FIFO_DEPTH, 4, stereo sample pairs buffered (power of 2, >= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request, sampled only at frame boundaries
s_valid  in  1  upstream sample pair valid
s_ready  out  1  FIFO can accept a pair
s_left  in  DATA_W  left sample, two's complement
s_right  in  DATA_W  right sample, two's complement
bclk  out  1  I2S bit clock
lrclk  out  1  word select; 0 = left, 1 = right
sdata  out  1  serial data, MSB first
underrun  out  1  one-clk pulse when a frame starts with the FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  pairs currently held
busy  out  1  1 while frames are being transmitted

Behaviour:
- Reset state: all outputs 0 except s_ready = 1. FIFO emptied, divider and bit counter cleared, state IDLE.
- Clock and reset: reset is asynchronous and active-high; clk is the only clock.
- FIFO push: on s_valid && s_ready. s_ready = (fifo_level < FIFO_DEPTH), computed from the current level only, so no push occurs when full even if a pop happens in the same cycle.
- FIFO level: a simultaneous push and pop leaves fifo_level unchanged. Pushes are accepted in any state.
- States: IDLE and RUN.
- IDLE outputs: bclk = 0, lrclk = 0, sdata = 0, busy = 0, divider held at 0.
- IDLE -> RUN: on the first clk with enable = 1. That cycle is frame start: div_cnt = 0, k = 0, pop.
- Divider: div_cnt counts 0 .. BCLK_DIV-1 and wraps. Registered bclk = 1 when div_cnt >= BCLK_DIV/2, else 0.
- Bit periods: each BCLK period k (0 .. 2*SLOT_W-1) starts on the clk where div_cnt = 0, which is the bclk falling edge. lrclk and sdata update only on these cycles; the receiver samples on the bclk rising edge.
- LRCLK: 1 for k in SLOT_W-1 .. 2*SLOT_W-2, otherwise 0. LRCLK therefore changes one BCLK before each channel MSB.
- SDATA: left sample bits MSB..LSB at k = 0 .. DATA_W-1, then 0 for k = DATA_W .. SLOT_W-1. Right sample bits at k = SLOT_W .. SLOT_W+DATA_W-1, then 0 to the end of the frame.
- Frame start (k = 0, div_cnt = 0): pop the FIFO head into the left/right shadow registers. If the FIFO is empty, load zeros and assert underrun for exactly that clk.
- Frame boundary sampling of enable: on the last clk of a frame (k = 2*SLOT_W-1, div_cnt = BCLK_DIV-1):
  - enable = 1: continue seamlessly to the next frame.
  - enable = 0: go to IDLE on the next clk.
- enable deasserted mid-frame: the current frame always completes. FIFO contents are preserved on stop.
- busy: 1 in RUN, 0 in IDLE.
- Frame length: 2*SLOT_W*BCLK_DIV clk cycles.
- Reset mid-frame: all outputs are forced to reset values immediately, with no partial-frame completion.

Test Plan:
Config for all tests: DATA_W=24, SLOT_W=32, BCLK_DIV=4, FIFO_DEPTH=4.
1. Push L=0xA5A5A5, R=0x5A5A5A, then enable=1 -> sdata at k=0..23 is 101001011010010110100101, 0 at k=24..31; right bits 0x5A5A5A at k=32..55; frame = 256 clk; bclk period = 4 clk, low 2, high 2.
2. Check LRCLK timing over 2 frames -> lrclk rises at the falling edge starting k=31 and falls at k=63, both exactly one BCLK before the MSB; sdata changes only when bclk falls.
3. enable=1 with the FIFO empty for 3 frames -> underrun pulses once per frame, 256 clk apart, each 1 clk wide; sdata = 0 throughout.
4. enable=0, push 5 pairs with s_valid held -> 4 accepted, fifo_level=4, s_ready=0; 5th accepted on the cycle after the first frame-start pop frees a slot.
5. Drop enable at k=10 -> frame completes to k=63; busy=0 and bclk=0 from the following clk; fifo_level unchanged after stop.
6. Assert reset at k=40 with 3 pairs queued -> same cycle: bclk=lrclk=sdata=busy=0, fifo_level=0, s_ready=1; re-enable restarts at k=0 with underrun.

Source files
------------

// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: I2S (Philips format) transmit sequencer.
// Buffers stereo pairs in a small FIFO, derives BCLK/LRCLK from clk and
// serialises one FIFO pair per frame, MSB first, one BCLK after LRCLK moves.
//
// Handshake (s_valid/s_ready): a pair transfers on every clk edge where
// s_valid && s_ready. s_ready depends only on the registered fifo_level,
// never on s_valid or on a same-cycle pop. The upstream must hold s_valid
// and the sample values stable until the transfer happens.
//
// All serial outputs are registered and aligned with the bit counters: the
// first clk of a frame shows k = 0, div_cnt = 0, bclk low and the left MSB.
module i2s_tx_ctrl #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_W-1:0]                 s_left,
  input  logic [DATA_W-1:0]                 s_right,
  output logic                              bclk,
  output logic                              lrclk,
  output logic                              sdata,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              busy,
  output logic                              dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int KW = $clog2(2 * SLOT_W);

  localparam logic [DW-1:0] DIV_LAST   = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(BCLK_DIV / 2);
  localparam logic [KW-1:0] K_LAST     = KW'(2 * SLOT_W - 1);
  localparam logic [KW-1:0] K_LR_RISE  = KW'(SLOT_W - 1);
  localparam logic [KW-1:0] K_LR_LAST  = KW'(2 * SLOT_W - 2);
  localparam logic [KW-1:0] K_SLOT     = KW'(SLOT_W);
  localparam logic [KW-1:0] K_DATA     = KW'(DATA_W);
  localparam logic [KW:0]   K_R_END    = (KW+1)'(SLOT_W + DATA_W);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [DW-1:0]       div_cnt, div_n;
  logic [KW-1:0]       k_cnt, k_n;
  logic                pop;        // frame start: consume one pair
  logic                pop_eff;    // frame start with data available
  logic                push;
  logic                fifo_empty;
  logic [DATA_W-1:0]   mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   head_l, head_r;
  logic [DATA_W-1:0]   shadow_l, shadow_r;
  logic [DATA_W-1:0]   lshift, rshift;
  logic                sdata_n;

  assign fifo_empty = (fifo_level == '0);
  assign s_ready    = (fifo_level < LEVEL_FULL);
  assign push       = s_valid && s_ready;
  assign pop_eff    = pop && !fifo_empty;
  assign head_l     = mem_l[rd_ptr];
  assign head_r     = mem_r[rd_ptr];
  assign busy       = (state == ST_RUN);
  assign dbg_state  = state;

  // Next-state logic: divider, bit counter, frame-boundary enable sampling.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    k_n     = k_cnt;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        div_n = '0;
        k_n   = '0;
        if (enable) begin
          state_n = ST_RUN;
          pop     = 1'b1;
        end
      end
      ST_RUN: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (k_cnt == K_LAST) begin
            k_n = '0;
            if (enable) pop = 1'b1;
            else        state_n = ST_IDLE;
          end else begin
            k_n = k_cnt + KW'(1);
          end
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Serial data bit for the upcoming clk; changes only at BCLK falling edges.
  always_comb begin
    sdata_n = sdata;
    lshift  = shadow_l << k_n;
    rshift  = shadow_r << (k_n - K_SLOT);
    if (state_n == ST_IDLE) begin
      sdata_n = 1'b0;
    end else if (div_n == '0) begin
      if (k_n == '0)
        sdata_n = pop_eff ? head_l[DATA_W-1] : 1'b0;
      else if (k_n < K_DATA)
        sdata_n = lshift[DATA_W-1];
      else if ((k_n >= K_SLOT) && ({1'b0, k_n} < K_R_END))
        sdata_n = rshift[DATA_W-1];
      else
        sdata_n = 1'b0;
    end
  end

  // Control state, counters, registered pin outputs and shadow samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      k_cnt    <= '0;
      bclk     <= 1'b0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      shadow_l <= '0;
      shadow_r <= '0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      k_cnt    <= k_n;
      bclk     <= (state_n == ST_RUN) && (div_n >= DIV_HALF);
      lrclk    <= (state_n == ST_RUN) && (k_n >= K_LR_RISE) && (k_n <= K_LR_LAST);
      sdata    <= sdata_n;
      underrun <= pop && fifo_empty;
      if (pop) begin
        shadow_l <= pop_eff ? head_l : '0;
        shadow_r <= pop_eff ? head_r : '0;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop in one clk cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_eff})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr] <= s_left;
      mem_r[wr_ptr] <= s_right;
    end
  end

endmodule
